// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 bus initiator converting a byte stream to sclk/mosi/ssel.
// Build option SPI_MASTER_RX_EN enables miso capture; without it rx_data/rx_valid stay 0.
module spi_master #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 4,
   parameter int CS_HOLD  = 4,
   parameter int CS_IDLE  = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso,
   output logic       ssel
);

   localparam int MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int MAX_CD = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
   localparam int MAX_PH = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CNT_W  = $clog2(MAX_PH + 1);

   localparam logic [CNT_W-1:0] DIV_END   = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] SETUP_END = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_END  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] GAP_END   = CNT_W'(CS_IDLE - 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      LOW,
      HIGH,
      NEXT,
      HOLD,
      GAP
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] phase_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift_reg;
   logic             last_r;
   logic             accept;
   logic             sample;
   logic             high_end;
   logic             last_bit;
   logic             miso_bit;

   assign tx_ready = (state == IDLE) || (state == NEXT);
   assign accept   = tx_valid && tx_ready;
   assign sample   = (state == HIGH) && (phase_cnt == '0);
   assign high_end = (state == HIGH) && (phase_cnt == DIV_END);
   assign last_bit = (bit_cnt == 3'd7);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (tx_valid) state_nxt = SETUP;
         SETUP:   if (phase_cnt == SETUP_END) state_nxt = LOW;
         LOW:     if (phase_cnt == DIV_END) state_nxt = HIGH;
         HIGH:    if (high_end) state_nxt = !last_bit ? LOW : (last_r ? HOLD : NEXT);
         NEXT:    if (tx_valid) state_nxt = LOW;
         HOLD:    if (phase_cnt == HOLD_END) state_nxt = GAP;
         GAP:     if (phase_cnt == GAP_END) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Phase counter restarts on every state change; it is parked in the open-ended waits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         phase_cnt <= '0;
      end else begin
         state <= state_nxt;
         if ((state_nxt != state) || (state == IDLE) || (state == NEXT))
            phase_cnt <= '0;
         else
            phase_cnt <= phase_cnt + 1'b1;
      end
   end

   // Pins are registered from the next state so they line up exactly with the state cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg <= '0;
         last_r    <= 1'b0;
         bit_cnt   <= '0;
         mosi      <= 1'b0;
         sclk      <= 1'b0;
         ssel      <= 1'b1;
         busy      <= 1'b0;
      end else begin
         sclk <= (state_nxt == HIGH);
         ssel <= (state_nxt == IDLE) || (state_nxt == GAP);
         busy <= (state_nxt != IDLE);

         if (accept) begin
            shift_reg <= tx_data;
            last_r    <= tx_last;
         end else if (sample) begin
            shift_reg <= {shift_reg[6:0], miso_bit};
         end

         if (accept)
            mosi <= tx_data[7];
         else if (high_end)
            mosi <= shift_reg[7];

         if ((state == IDLE) && accept)
            bit_cnt <= '0;
         else if (high_end)
            bit_cnt <= bit_cnt + 1'b1;
      end
   end

`ifdef SPI_MASTER_RX_EN
   logic byte_done;

   assign miso_bit  = miso;
   assign byte_done = high_end && last_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data  <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_valid <= byte_done;
         if (byte_done)
            rx_data <= shift_reg;
      end
   end
`else
   logic unused_miso;

   assign unused_miso = miso;
   assign miso_bit    = 1'b0;
   assign rx_data     = '0;
   assign rx_valid    = 1'b0;
`endif

endmodule
